// File: rtl/pipeline_latealu_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_latealu_pkg
// Shared definitions for the late-ALU stage: late-op codes, exception codes,
// the mul/div engine state type and small op-classification helpers. The ALU
// stage imports the same package so both stages agree on every encoding.
// ---------------------------------------------------------------------------
package pipeline_latealu_pkg;

    // Late-op codes
    localparam logic [5:0] OP_SLL   = 6'b000001;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_MULT  = 6'b000100;
    localparam logic [5:0] OP_MULTU = 6'b000101;
    localparam logic [5:0] OP_DIV   = 6'b000110;
    localparam logic [5:0] OP_DIVU  = 6'b000111;
    localparam logic [5:0] OP_MFHI  = 6'b001000;
    localparam logic [5:0] OP_MFLO  = 6'b001001;
    localparam logic [5:0] OP_MTHI  = 6'b001010;
    localparam logic [5:0] OP_MTLO  = 6'b001011;

    // Exception codes
    localparam logic [2:0] EXC_NONE     = 3'b000;
    localparam logic [2:0] EXC_BAD_OP   = 3'b001;
    localparam logic [2:0] EXC_OVERFLOW = 3'b010;
    localparam logic [2:0] EXC_SYSCALL  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    // Ops that touch HI/LO or the engine; these must wait for a busy engine.
    function automatic logic is_hilo_op(input logic [5:0] op);
        return (op >= OP_MULT) && (op <= OP_MTLO);
    endfunction

    // Ops that launch the multiply/divide engine.
    function automatic logic is_start_op(input logic [5:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    // Magnitude of v when treated as signed; unchanged for unsigned ops.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic use_sign);
        return (use_sign && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/pipeline_latealu_muldiv_engine.sv
// ---------------------------------------------------------------------------
// latealu_muldiv_engine
// Iterative 32-cycle multiply/divide unit that owns the architectural HI/LO
// registers. Signed operands are reduced to magnitudes at start and the sign
// is restored in a single FIX cycle before HI/LO are written.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         launch op with operands a, b (only honoured in IDLE)
//   op            late-op code (mult/multu/div/divu)
//   a, b          rs / rt operands
//   mthi_we       write wdata into HI (honoured in IDLE)
//   mtlo_we       write wdata into LO (honoured in IDLE)
//   wdata         data for mthi/mtlo
//   busy          engine is not IDLE
//   hi, lo        architectural HI/LO
// ---------------------------------------------------------------------------
module latealu_muldiv_engine
    import pipeline_latealu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state;
    logic [4:0]  cnt;
    logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] operand;   // mul: |multiplicand|; div: |divisor|
    logic        is_mul;
    logic        neg_lo;    // negate product (mul) or quotient (div)
    logic        neg_hi;    // negate remainder (div only)

    logic        op_signed;
    logic        op_mul;
    logic [63:0] acc_step;
    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic [33:0] div_diff;
    logic [63:0] product;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign busy      = (state != ST_IDLE);

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        acc_step  = acc;
        mul_sum   = '0;
        rem_shift = '0;
        div_diff  = '0;
        if (is_mul) begin
            mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
            acc_step = {mul_sum, acc[31:1]};
        end else begin
            rem_shift = {acc[63:32], acc[31]};
            div_diff  = {1'b0, rem_shift} - {2'b00, operand};
            if (!div_diff[33]) acc_step = {div_diff[31:0], acc[30:0], 1'b1};
            else               acc_step = {rem_shift[31:0], acc[30:0], 1'b0};
        end
    end

    // Sign correction applied in FIX.
    always_comb begin
        product = neg_lo ? -acc : acc;
        if (is_mul) begin
            fix_hi = product[63:32];
            fix_lo = product[31:0];
        end else begin
            fix_hi = neg_hi ? -acc[63:32] : acc[63:32];
            fix_lo = neg_lo ? -acc[31:0]  : acc[31:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            is_mul  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        is_mul <= op_mul;
                        if (!op_mul && (b == 32'd0)) begin
                            // Divide by zero skips iteration; FIX writes HI=a, LO=all ones.
                            acc    <= {a, 32'hFFFF_FFFF};
                            neg_lo <= 1'b0;
                            neg_hi <= 1'b0;
                            state  <= ST_FIX;
                        end else begin
                            cnt    <= '0;
                            neg_lo <= op_signed && (a[31] ^ b[31]);
                            neg_hi <= op_signed && !op_mul && a[31];
                            if (op_mul) begin
                                acc     <= {32'd0, abs32(b, op_signed)};
                                operand <= abs32(a, op_signed);
                            end else begin
                                acc     <= {32'd0, abs32(a, op_signed)};
                                operand <= abs32(b, op_signed);
                            end
                            state <= ST_RUN;
                        end
                    end else begin
                        if (mthi_we) hi <= wdata;
                        if (mtlo_we) lo <= wdata;
                    end
                end
                ST_RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= ST_FIX;
                end
                ST_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_latealu.sv
// ---------------------------------------------------------------------------
// pipeline_latealu
// Late-ALU pipeline stage: single-cycle barrel shifts, HI/LO moves and the
// launch of the background multiply/divide engine. Stalls only when a HI/LO
// op meets a busy engine; the stalled cycle retires a bubble.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   latealu_enable    late op requested
//   latealu_op        late-op code
//   latealu_a0        shift source / rs operand
//   latealu_a1        shift amount [4:0] / rt operand
//   rd_index_in       destination from ALU stage
//   rd_value_in       early result from ALU stage
//   exception_in      exception code from ALU stage
//   rd_index          registered destination (0 = no write)
//   rd_value          registered result
//   exception         registered exception code
//   stall             combinational; upstream holds inputs while high
//   muldiv_busy       engine running
// ---------------------------------------------------------------------------
module pipeline_latealu
    import pipeline_latealu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        latealu_enable,
    input  logic [5:0]  latealu_op,
    input  logic [31:0] latealu_a0,
    input  logic [31:0] latealu_a1,
    input  logic [4:0]  rd_index_in,
    input  logic [31:0] rd_value_in,
    input  logic [2:0]  exception_in,
    output logic [4:0]  rd_index,
    output logic [31:0] rd_value,
    output logic [2:0]  exception,
    output logic        stall,
    output logic        muldiv_busy
);

    logic [31:0] hi;
    logic [31:0] lo;
    logic        exec;      // enabled, exception-free and not stalled: side effects allowed
    logic        md_start;
    logic        mthi_we;
    logic        mtlo_we;
    logic [4:0]  shamt;
    logic [4:0]  next_index;
    logic [31:0] next_value;
    logic [2:0]  next_exc;

    assign stall    = latealu_enable && muldiv_busy && is_hilo_op(latealu_op);
    assign exec     = latealu_enable && (exception_in == EXC_NONE) && !stall;
    assign md_start = exec && is_start_op(latealu_op);
    assign mthi_we  = exec && (latealu_op == OP_MTHI);
    assign mtlo_we  = exec && (latealu_op == OP_MTLO);
    assign shamt    = latealu_a1[4:0];

    latealu_muldiv_engine u_engine (
        .clk     (clk),
        .rst     (rst),
        .start   (md_start),
        .op      (latealu_op),
        .a       (latealu_a0),
        .b       (latealu_a1),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .wdata   (latealu_a0),
        .busy    (muldiv_busy),
        .hi      (hi),
        .lo      (lo)
    );

    always_comb begin
        next_index = rd_index_in;
        next_value = rd_value_in;
        next_exc   = exception_in;
        if (stall) begin
            next_index = '0;
            next_value = '0;
            next_exc   = EXC_NONE;
        end else if (latealu_enable) begin
            if (exception_in != EXC_NONE) begin
                next_index = '0;
            end else begin
                case (latealu_op)
                    OP_SLL:  next_value = latealu_a0 << shamt;
                    OP_SRL:  next_value = latealu_a0 >> shamt;
                    OP_SRA:  next_value = $unsigned($signed(latealu_a0) >>> shamt);
                    OP_MFHI: next_value = hi;
                    OP_MFLO: next_value = lo;
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: begin
                        next_index = '0;
                        next_value = '0;
                    end
                    default: begin
                        next_index = '0;
                        next_value = '0;
                        next_exc   = EXC_BAD_OP;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_index  <= '0;
            rd_value  <= '0;
            exception <= EXC_NONE;
        end else begin
            rd_index  <= next_index;
            rd_value  <= next_value;
            exception <= next_exc;
        end
    end

endmodule
